// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, FSM state type and handshake constants shared by the MDU.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MUL, ST_ACC, ST_DIV_ON, ST_DIV_ZERO, ST_END
    } mdu_state_e;

    localparam logic MDU_STOP      = 1'b0;
    localparam logic MDU_START     = 1'b1;
    localparam logic MDU_READY     = 1'b1;
    localparam logic MDU_NOT_READY = 1'b0;

    function automatic logic op_signed(input mdu_op_e op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic op_acc(input mdu_op_e op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic op_sub(input mdu_op_e op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic op_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring radix-2 divider, one quotient bit per clock.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, rem_q, div_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;
    logic [WIDTH:0]   shift_d, diff_d;
    logic             last_d;

    // the dividend shifts out of quo_q while quotient bits shift in behind it
    assign shift_d = {rem_q, quo_q[WIDTH-1]};
    assign diff_d  = shift_d - {1'b0, div_q};
    assign last_d  = cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= run_q && last_d;
            if (run_q) begin
                rem_q <= diff_d[WIDTH] ? shift_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
                cnt_q <= cnt_q + 1'b1;
                run_q <= !last_d;
            end
        end
    end

    assign quot_o = quo_q;
    assign rem_o  = rem_q;
    assign done_o = done_q;

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit producing {HI,LO}; define MDU_MACC_EN to enable MADD*/MSUB* accumulation.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);
    mdu_state_e         state_q;
    mdu_op_e            op_d, op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag1_d, mag2_d, quot, rem, quot_d, rem_d;
    logic [2*WIDTH-1:0] ea_d, eb_d, prod_d, result_q;
    logic               ready_q, dbz_q, div_go_d, div_done;

    assign op_d     = mdu_op_e'(op_i[2:0]);
    assign mag1_d   = (op_signed(op_d) && op1_i[WIDTH-1]) ? -op1_i : op1_i;
    assign mag2_d   = (op_signed(op_d) && op2_i[WIDTH-1]) ? -op2_i : op2_i;
    assign div_go_d = state_q == ST_IDLE && start_i == MDU_START && !annul_i
                      && op_div(op_d) && op2_i != '0;

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_go_d),
        .annul_i    (annul_i),
        .dividend_i (mag1_d),
        .divisor_i  (mag2_d),
        .quot_o     (quot),
        .rem_o      (rem),
        .done_o     (div_done)
    );

    // the low 2*WIDTH bits of a product of sign-extended operands are the signed product
    assign ea_d   = op_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign eb_d   = op_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod_d = ea_d * eb_d;
    assign quot_d = (op_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot : quot;
    assign rem_d  = (op_signed(op_q) && a_q[WIDTH-1]) ? -rem : rem;

`ifdef MDU_MACC_EN
    logic [2*WIDTH-1:0] hilo_q, prod_q;
`else
    logic unused_hilo;
    assign unused_hilo = ^hilo_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ready_q  <= MDU_NOT_READY;
            dbz_q    <= 1'b0;
        end else if (annul_i) begin
            state_q <= ST_IDLE;
            ready_q <= MDU_NOT_READY;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i == MDU_START) begin
                    op_q    <= op_d;
                    a_q     <= op1_i;
                    b_q     <= op2_i;
`ifdef MDU_MACC_EN
                    hilo_q  <= hilo_i;
`endif
                    state_q <= !op_div(op_d) ? ST_MUL : (op2_i == '0 ? ST_DIV_ZERO : ST_DIV_ON);
                end
                ST_MUL: begin
`ifdef MDU_MACC_EN
                    if (op_acc(op_q)) begin
                        prod_q  <= prod_d;
                        state_q <= ST_ACC;
                    end else begin
                        result_q <= prod_d;
                        ready_q  <= MDU_READY;
                        state_q  <= ST_END;
                    end
`else
                    result_q <= op_acc(op_q) ? '0 : prod_d;
                    ready_q  <= MDU_READY;
                    state_q  <= ST_END;
`endif
                end
`ifdef MDU_MACC_EN
                ST_ACC: begin
                    result_q <= op_sub(op_q) ? hilo_q - prod_q : hilo_q + prod_q;
                    ready_q  <= MDU_READY;
                    state_q  <= ST_END;
                end
`endif
                ST_DIV_ON: if (div_done) begin
                    result_q <= {rem_d, quot_d};
                    ready_q  <= MDU_READY;
                    state_q  <= ST_END;
                end
                ST_DIV_ZERO: begin
                    result_q <= '0;
                    dbz_q    <= 1'b1;
                    ready_q  <= MDU_READY;
                    state_q  <= ST_END;
                end
                ST_END: if (start_i == MDU_STOP) begin
                    ready_q <= MDU_NOT_READY;
                    dbz_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result_o      = result_q;
    assign ready_o       = ready_q;
    assign busy_o        = state_q != ST_IDLE;
    assign div_by_zero_o = dbz_q;

endmodule
